// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32xN integer register file and commit counter
module wb_regfile #(
    parameter int N = 32,
    parameter logic [N-1:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [N-1:0] GP_INIT = 32'h1000_8000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_4_i,
    input  logic         mem_to_reg_i,
    input  logic         reg_write_i,
    input  logic         jalr_i,
    input  logic [4:0]   write_register_i,
    input  logic [N-1:0] alu_result_i,
    input  logic [N-1:0] read_mem_data_i,
    input  logic [4:0]   read_register_1_i,
    input  logic [4:0]   read_register_2_i,
    output logic [N-1:0] read_data_1_o,
    output logic [N-1:0] read_data_2_o,
    output logic [N-1:0] wb_data_o,
    output logic [4:0]   wb_register_o,
    output logic         wb_en_o,
    output logic [31:0]  commit_count_o
);
    logic [N-1:0] regs [32];
    logic [31:0]  count_q;

    // write-back select and forwarding export; link address beats load data beats ALU
    always_comb begin
        wb_data_o     = jalr_i ? pc_4_i : mem_to_reg_i ? read_mem_data_i : alu_result_i;
        wb_register_o = write_register_i;
        wb_en_o       = reg_write_i && (write_register_i != 5'd0);
    end

    // storage; x0 is reset to zero and never enabled, so it reads as zero forever
    for (genvar g = 0; g < 32; g++) begin : g_reg
        // one register per index, written on the rising edge when addressed
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                regs[g] <= (g == 2) ? SP_INIT : (g == 3) ? GP_INIT : '0;
            else if (wb_en_o && write_register_i == 5'(g))
                regs[g] <= wb_data_o;
        end
    end

    // count committed writes; wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else if (wb_en_o)
            count_q <= count_q + 32'd1;
    end

    // combinational read ports with no bypass; same-cycle visibility comes from the half-cycle split
    always_comb begin
        read_data_1_o  = (read_register_1_i == 5'd0) ? '0 : regs[read_register_1_i];
        read_data_2_o  = (read_register_2_i == 5'd0) ? '0 : regs[read_register_2_i];
        commit_count_o = count_q;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and integer register file for the 5-stage RISC-V pipeline. It takes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32×N register file. It serves the two combinational read ports used by the decode stage. It also exports the committed write (data, index, enable) to the EX-stage forwarding unit, and keeps a commit counter for debug and performance visibility.

## Interface
Parameters:
- N, 32, data width of registers and datapath
- SP_INIT, 32'h7FFF_EFFC, reset value of x2 (sp)
- GP_INIT, 32'h1000_8000, reset value of x3 (gp)

Ports:
- clk  input  1  system clock; register file writes on rising edge
- reset  input  1  asynchronous, active-low reset
- pc_4_i  input  N  PC+4 from MEM/WB
- mem_to_reg_i  input  1  select load data
- reg_write_i  input  1  write enable from MEM/WB
- jalr_i  input  1  select PC+4 (jal/jalr link)
- write_register_i  input  5  destination index rd
- alu_result_i  input  N  ALU result from MEM/WB
- read_mem_data_i  input  N  load data from MEM/WB
- read_register_1_i  input  5  rs1 index from decode
- read_register_2_i  input  5  rs2 index from decode
- read_data_1_o  output  N  rs1 value, combinational
- read_data_2_o  output  N  rs2 value, combinational
- wb_data_o  output  N  selected write-back value, combinational
- wb_register_o  output  5  equals write_register_i
- wb_en_o  output  1  reg_write_i AND (write_register_i != 0)
- commit_count_o  output  32  number of committed register writes

## Operation
- Write-back select has fixed priority. jalr_i=1 selects pc_4_i. Otherwise mem_to_reg_i=1 selects read_mem_data_i. Otherwise the select is alu_result_i. The result drives wb_data_o.
- Commit rule: on rising edge of clk with wb_en_o=1, regs[write_register_i] <= wb_data_o.
- x0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0.
  - A write to x0 does not count as a commit.
- Reads are combinational from the storage array.
  - There is no internal write→read bypass.
  - Same-cycle visibility comes from the clock-phase split described under Timing.
- Each commit increments commit_count_o by 1. It wraps from 32'hFFFF_FFFF to 0 with no flag.
- Reset (reset=0, asynchronous, overrides clk):
  - All registers cleared to 0, except x2=SP_INIT and x3=GP_INIT.
  - commit_count_o=0.
  - While reset is low, no write takes effect regardless of inputs.
- Reset asserted mid-cycle:
  - The array clears immediately.
  - A write whose rising edge occurs while reset is low is lost.
  - The first commit is possible on the first rising edge after reset rises.
- X-free requirement: read outputs must never be X after reset, including for indices never written.

## Timing
- Pipeline registers (including MEM/WB) update on the falling edge of clk. This block writes on the rising edge, half a cycle later.
- Write-back latency:
  - Rising edge of clk writes the register file.
  - The following falling edge captures the decode-stage read into ID/EX.
  - Net result: an instruction in WB and a dependent instruction in ID in the same cycle see the new value, so no WB→ID hazard stall or forwarding is needed.
- wb_data_o, wb_register_o and wb_en_o are valid combinationally from the MEM/WB outputs during the whole cycle. The EX forwarding unit uses them.
- read_data_x_o changes right after the rising edge when the addressed register is written. Otherwise it follows read_register_x_i combinationally.
- commit_count_o updates on the same rising edge as the write.

## Test plan
- Reset values: hold reset=0 for 2 cycles, then release.
  - Expected: every index reads 0, except x2=32'h7FFF_EFFC and x3=32'h1000_8000. commit_count_o=0.
- Select priority: rd=5, reg_write=1, alu=32'h11, mem=32'h22, pc_4=32'h33. Step through {jalr,mem_to_reg} = 00, 01, 10, 11, one cycle each.
  - Expected x5 after each edge: 32'h11, 32'h22, 32'h33, 32'h33. commit_count_o=4.
- x0 guard: rd=0, reg_write=1, alu=32'hDEAD_BEEF.
  - Expected: read of x0 stays 0, wb_en_o=0, commit_count_o unchanged.
- Half-cycle visibility: write x7=32'hCAFE_F00D while read_register_1_i=7.
  - Expected: read_data_1_o=32'hCAFE_F00D after the rising edge and before the next falling edge. x7 with reg_write=0 is unchanged.
- Reset mid-operation: write x10=32'h1234, then pull reset low between edges.
  - Expected: x10 reads 0 immediately, and x2 returns to SP_INIT. A write presented during reset is dropped, and the first post-reset write commits with count=1.
- Counter wrap: force commit_count_o to 32'hFFFF_FFFF, then commit one write.
  - Expected: commit_count_o=0, and the write still lands.
